// File: rtl/sprite_scheduler.sv
// sprite_scheduler: frame-level overlay scheduler for the pixel loader.
// It queues overlay requests, picks one overlay per frame by fixed priority,
// holds each overlay for HOLD_FRAMES frames, and changes SPRITES_EN only at
// frame boundaries.
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   ENABLE     run request; low drops to idle at the next frame boundary
//   PAUSE      level; masks SPRITES_EN[7] with no latency
//   REQ[6:0]   request bits {blue,green,red,yellow,lose,win,pwr}
//   FRAME_DONE one-cycle pulse at the end of each loaded frame
//   SPRITES_EN {run flag, overlay one-hot}, registered (bit 7 masked by PAUSE)
//   ACK[6:0]   one-cycle pulse for the overlay whose hold period ended
//   BUSY       a request is pending or an overlay is shown
`timescale 1ns/1ps
module sprite_scheduler #(
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       PAUSE,
  input  logic [6:0] REQ,
  input  logic       FRAME_DONE,
  output logic [7:0] SPRITES_EN,
  output logic [6:0] ACK,
  output logic       BUSY
);

  localparam int unsigned SPR_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam logic [SPR_W-1:0] LOSE_BIT  = SPR_W'(7'h04);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BG   = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t             state;
  logic [SPR_W-1:0]   pend;
  logic [SPR_W-1:0]   cur;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         en_q;
  logic [SPR_W-1:0]   ack_q;
  logic               busy_q;

  logic [SPR_W-1:0]   sel;
  logic               fd_bg;
  logic               fd_show;
  logic               preempt;
  logic               expire;
  logic               take_next;
  logic [SPR_W-1:0]   clr;
  logic [SPR_W-1:0]   pend_nx;
  logic               show_nx;

  // Fixed priority: lose, win, pwr, blue, green, red, yellow.
  function automatic logic [SPR_W-1:0] pick(input logic [SPR_W-1:0] p);
    if      (p[2]) return SPR_W'(7'h04);
    else if (p[1]) return SPR_W'(7'h02);
    else if (p[0]) return SPR_W'(7'h01);
    else if (p[6]) return SPR_W'(7'h40);
    else if (p[5]) return SPR_W'(7'h20);
    else if (p[4]) return SPR_W'(7'h10);
    else if (p[3]) return SPR_W'(7'h08);
    else           return '0;
  endfunction

  // Frame-boundary decisions shared by the pending register, BUSY and the FSM.
  always_comb begin
    sel       = pick(pend);
    fd_bg     = (state == BG)   && FRAME_DONE && ENABLE;
    fd_show   = (state == SHOW) && FRAME_DONE && ENABLE;
    preempt   = fd_show && pend[2] && !cur[2];
    expire    = fd_show && !preempt && (cnt == '0);
    take_next = (fd_bg || expire) && (pend != '0);
    clr       = '0;
    if (preempt)        clr = LOSE_BIT;
    else if (take_next) clr = sel;
    // A request on the bit being cleared wins, so it is re-queued.
    pend_nx   = (pend & ~clr) | REQ;
    show_nx   = ((state == SHOW) && !FRAME_DONE) || (fd_show && !expire) || take_next;
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      pend   <= '0;
      cur    <= '0;
      cnt    <= '0;
      en_q   <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      pend   <= pend_nx;
      busy_q <= (pend_nx != '0) || show_nx;
      ack_q  <= '0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            state <= BG;
            en_q  <= 8'h80;
          end
        end
        BG: begin
          if (FRAME_DONE) begin
            if (!ENABLE) begin
              state <= IDLE;
              en_q  <= '0;
            end else if (take_next) begin
              state <= SHOW;
              cur   <= sel;
              cnt   <= HOLD_LOAD;
              en_q  <= {1'b1, sel};
            end
          end
        end
        SHOW: begin
          if (FRAME_DONE) begin
            if (!ENABLE) begin
              state <= IDLE;
              cur   <= '0;
              en_q  <= '0;
            end else if (preempt) begin
              ack_q <= cur;
              cur   <= LOSE_BIT;
              cnt   <= HOLD_LOAD;
              en_q  <= {1'b1, LOSE_BIT};
            end else if (expire) begin
              ack_q <= cur;
              if (take_next) begin
                cur  <= sel;
                cnt  <= HOLD_LOAD;
                en_q <= {1'b1, sel};
              end else begin
                state <= BG;
                cur   <= '0;
                en_q  <= 8'h80;
              end
            end else begin
              // Not expired here means cnt is nonzero, so no wrap.
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cur   <= '0;
          en_q  <= '0;
        end
      endcase
    end
  end

  // PAUSE stalls the loader by masking the run flag combinationally.
  assign SPRITES_EN = {en_q[7] & ~PAUSE, en_q[6:0]};
  assign ACK        = ack_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed scenarios plus random
// stimulus, compared each cycle with a frame-level behavioural model.
`timescale 1ns/1ps
module tb_sprite_scheduler;

  localparam int unsigned H = 2;

  logic       CLK;
  logic       RESET;
  logic       ENABLE;
  logic       PAUSE;
  logic [6:0] REQ;
  logic       FRAME_DONE;
  logic [7:0] SPRITES_EN;
  logic [6:0] ACK;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 background, 2 showing overlay m_cur;
  // m_left = frame pulses still to go before the overlay is acknowledged.
  int       m_mode;
  int       m_cur;
  int       m_left;
  bit [6:0] m_pend;
  bit [7:0] m_en;
  bit [6:0] m_ack;

  typedef struct {
    logic [6:0] rq;
    bit         fd;
    int         xe;
    int         xa;
  } step_t;

  sprite_scheduler #(.HOLD_FRAMES(H)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAUSE(PAUSE), .REQ(REQ),
    .FRAME_DONE(FRAME_DONE), .SPRITES_EN(SPRITES_EN), .ACK(ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int pick_idx(input bit [6:0] p);
    int order [7] = '{2, 1, 0, 6, 5, 4, 3};
    for (int k = 0; k < 7; k++) if (p[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = -1; m_left = 0; m_pend = '0; m_en = '0; m_ack = '0;
  endtask

  task automatic model_step(input bit en, input bit [6:0] r, input bit fd);
    bit [6:0] clrm = '0;
    int k;
    m_ack = '0;
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (fd) begin
      if (!en) begin
        m_mode = 0; m_cur = -1;
      end else if (m_mode == 2 && m_pend[2] && m_cur != 2) begin
        m_ack[m_cur] = 1'b1; m_cur = 2; clrm[2] = 1'b1; m_left = H;
      end else begin
        if (m_mode == 2) begin
          m_left--;
          if (m_left == 0) begin
            m_ack[m_cur] = 1'b1; m_mode = 1; m_cur = -1;
          end
        end
        if (m_mode == 1) begin
          k = pick_idx(m_pend);
          if (k >= 0) begin
            clrm[k] = 1'b1; m_cur = k; m_left = H; m_mode = 2;
          end
        end
      end
    end
    m_pend = (m_pend & ~clrm) | r;
    if (m_mode == 0)      m_en = 8'h00;
    else if (m_mode == 1) m_en = 8'h80;
    else                  m_en = 8'h80 | (8'h01 << m_cur);
  endtask

  function automatic logic [7:0] exp_en();
    return {m_en[7] & ~PAUSE, m_en[6:0]};
  endfunction

  function automatic logic exp_busy();
    return (m_pend != '0) || (m_mode == 2);
  endfunction

  // Drive one cycle of REQ/FRAME_DONE, advance the model, sample after the edge.
  task automatic cyc(input logic [6:0] r, input bit fd);
    REQ = r; FRAME_DONE = fd;
    @(posedge CLK);
    model_step(ENABLE, r, fd);
    #1;
    REQ = '0; FRAME_DONE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b1; PAUSE = 1'b0; REQ = 7'h7f; FRAME_DONE = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (SPRITES_EN !== 8'h00 || ACK !== 7'h00 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%h ack=%h busy=%b want 00 00 0", SPRITES_EN, ACK, BUSY);
    end
    ENABLE = 1'b0; REQ = '0; FRAME_DONE = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    cyc(7'h00, 1'b1);
    checks++;
    if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
      errors++;
      $display("FAIL reset_idle: en=%h ack=%h busy=%b want %h %h %b",
               SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
    end
  endtask

  task automatic test_basic();
    step_t s [8];
    s = '{'{7'h00, 1'b0, 'h80, 0}, '{7'h40, 1'b0, 'h80, 0},
          '{7'h00, 1'b1, 'hC0, 0}, '{7'h00, 1'b0, 'hC0, 0},
          '{7'h00, 1'b1, 'hC0, 0}, '{7'h00, 1'b0, 'hC0, 0},
          '{7'h00, 1'b1, 'h80, 'h40}, '{7'h00, 1'b0, 'h80, 0}};
    ENABLE = 1'b1; PAUSE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(s[i].rq, s[i].fd);
      checks++;
      if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL basic_model[%0d]: en=%h ack=%h busy=%b want %h %h %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
      end
      if (s[i].xe >= 0) begin
        checks++;
        if (SPRITES_EN !== 8'(s[i].xe)) begin
          errors++; $display("FAIL basic_en[%0d]: got %h want %h", i, SPRITES_EN, 8'(s[i].xe));
        end
      end
      if (s[i].xa >= 0) begin
        checks++;
        if (ACK !== 7'(s[i].xa)) begin
          errors++; $display("FAIL basic_ack[%0d]: got %h want %h", i, ACK, 7'(s[i].xa));
        end
      end
    end
  endtask

  task automatic test_priority();
    step_t s [10];
    s = '{'{7'h49, 1'b0, 'h80, 0}, '{7'h00, 1'b1, 'h81, 0},
          '{7'h00, 1'b1, 'h81, 0}, '{7'h00, 1'b1, 'hC0, 'h01},
          '{7'h00, 1'b0, 'hC0, 0}, '{7'h00, 1'b1, 'hC0, 0},
          '{7'h00, 1'b1, 'h88, 'h40}, '{7'h00, 1'b1, 'h88, 0},
          '{7'h00, 1'b1, 'h80, 'h08}, '{7'h00, 1'b0, 'h80, 0}};
    for (int i = 0; i < 10; i++) begin
      cyc(s[i].rq, s[i].fd);
      checks++;
      if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL prio_model[%0d]: en=%h ack=%h busy=%b want %h %h %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
      end
      if (s[i].xe >= 0) begin
        checks++;
        if (SPRITES_EN !== 8'(s[i].xe)) begin
          errors++; $display("FAIL prio_en[%0d]: got %h want %h", i, SPRITES_EN, 8'(s[i].xe));
        end
      end
      if (s[i].xa >= 0) begin
        checks++;
        if (ACK !== 7'(s[i].xa)) begin
          errors++; $display("FAIL prio_ack[%0d]: got %h want %h", i, ACK, 7'(s[i].xa));
        end
      end
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL prio_idle_busy: got %b want 0", BUSY);
    end
  endtask

  task automatic test_preempt();
    step_t s [6];
    s = '{'{7'h20, 1'b0, 'h80, 0}, '{7'h00, 1'b1, 'hA0, 0},
          '{7'h04, 1'b0, 'hA0, 0}, '{7'h00, 1'b1, 'h84, 'h20},
          '{7'h00, 1'b1, 'h84, 0}, '{7'h00, 1'b1, 'h80, 'h04}};
    for (int i = 0; i < 6; i++) begin
      cyc(s[i].rq, s[i].fd);
      checks++;
      if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL preempt_model[%0d]: en=%h ack=%h busy=%b want %h %h %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
      end
      if (s[i].xe >= 0) begin
        checks++;
        if (SPRITES_EN !== 8'(s[i].xe)) begin
          errors++; $display("FAIL preempt_en[%0d]: got %h want %h", i, SPRITES_EN, 8'(s[i].xe));
        end
      end
      if (s[i].xa >= 0) begin
        checks++;
        if (ACK !== 7'(s[i].xa)) begin
          errors++; $display("FAIL preempt_ack[%0d]: got %h want %h", i, ACK, 7'(s[i].xa));
        end
      end
    end
  endtask

  task automatic test_set_over_clear();
    step_t s [6];
    s = '{'{7'h10, 1'b0, 'h80, 0}, '{7'h10, 1'b1, 'h90, 0},
          '{7'h00, 1'b1, 'h90, 0}, '{7'h00, 1'b1, 'h90, 'h10},
          '{7'h00, 1'b1, 'h90, 0}, '{7'h00, 1'b1, 'h80, 'h10}};
    for (int i = 0; i < 6; i++) begin
      cyc(s[i].rq, s[i].fd);
      checks++;
      if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL soc_model[%0d]: en=%h ack=%h busy=%b want %h %h %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
      end
      if (s[i].xe >= 0) begin
        checks++;
        if (SPRITES_EN !== 8'(s[i].xe)) begin
          errors++; $display("FAIL soc_en[%0d]: got %h want %h", i, SPRITES_EN, 8'(s[i].xe));
        end
      end
      if (s[i].xa >= 0) begin
        checks++;
        if (ACK !== 7'(s[i].xa)) begin
          errors++; $display("FAIL soc_ack[%0d]: got %h want %h", i, ACK, 7'(s[i].xa));
        end
      end
    end
  endtask

  task automatic test_pause_enable();
    ENABLE = 1'b1; PAUSE = 1'b0;
    cyc(7'h10, 1'b0);
    cyc(7'h00, 1'b1);
    checks++;
    if (SPRITES_EN !== 8'h90) begin
      errors++; $display("FAIL pause_pre: got %h want 90", SPRITES_EN);
    end
    PAUSE = 1'b1; #1;
    checks++;
    if (SPRITES_EN !== 8'h10) begin
      errors++; $display("FAIL pause_mask: got %h want 10", SPRITES_EN);
    end
    cyc(7'h00, 1'b0);
    checks++;
    if (SPRITES_EN !== 8'h10 || SPRITES_EN !== exp_en()) begin
      errors++; $display("FAIL pause_hold: got %h want 10 (model %h)", SPRITES_EN, exp_en());
    end
    PAUSE = 1'b0; #1;
    checks++;
    if (SPRITES_EN !== 8'h90) begin
      errors++; $display("FAIL pause_release: got %h want 90", SPRITES_EN);
    end
    ENABLE = 1'b0;
    cyc(7'h00, 1'b1);
    checks++;
    if (SPRITES_EN !== 8'h00 || ACK !== 7'h00) begin
      errors++; $display("FAIL disable: en=%h ack=%h want 00 00", SPRITES_EN, ACK);
    end
    cyc(7'h00, 1'b0);
    checks++;
    if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== 1'b0) begin
      errors++; $display("FAIL disable_idle: en=%h ack=%h busy=%b want %h %h 0",
                         SPRITES_EN, ACK, BUSY, exp_en(), m_ack);
    end
  endtask

  task automatic test_async_reset();
    ENABLE = 1'b1; PAUSE = 1'b0;
    cyc(7'h00, 1'b0);
    cyc(7'h40, 1'b0);
    cyc(7'h00, 1'b1);
    cyc(7'h02, 1'b0);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (SPRITES_EN !== 8'h00 || ACK !== 7'h00 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%h ack=%h busy=%b want 00 00 0", SPRITES_EN, ACK, BUSY);
    end
    model_reset();
    @(negedge CLK); RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(7'h00, (i % 2) == 1);
      checks++;
      if (ACK !== 7'h00 || SPRITES_EN !== exp_en() || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL post_reset[%0d]: en=%h ack=%h busy=%b want %h 00 %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), exp_busy());
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] r;
    bit         fd;
    for (int i = 0; i < 800; i++) begin
      ENABLE = ($urandom_range(0, 24) != 0);
      PAUSE  = ($urandom_range(0, 9) == 0);
      r      = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00;
      fd     = ($urandom_range(0, 3) == 0);
      cyc(r, fd);
      checks++;
      if (SPRITES_EN !== exp_en() || ACK !== m_ack || BUSY !== exp_busy()) begin
        errors++;
        $display("FAIL random[%0d]: en=%h ack=%h busy=%b want %h %h %b",
                 i, SPRITES_EN, ACK, BUSY, exp_en(), m_ack, exp_busy());
      end
    end
  endtask

  initial begin
    CLK = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_preempt();
    test_set_over_clear();
    test_pause_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Frame-level scheduler that drives the `SPRITES_EN` vector of the pixel loader. It queues sprite requests from the game FSM (colour pads, win/lose banners, power indicator) and decides which overlay sprite is active in each frame. It holds each overlay for a programmable number of frames and pauses the loader on demand. Every change to `SPRITES_EN` happens only at a frame boundary, so the loader never sees its sprite selection change mid-frame.

## Interface
- `HOLD_FRAMES`, default 30: frames each overlay sprite stays enabled (1..255).
- `CLK` input 1: system clock; all logic on the rising edge.
- `RESET` input 1: asynchronous, active-high; clears all state.
- `ENABLE` input 1: run request. Low means drop to IDLE at the next frame boundary.
- `PAUSE` input 1: level. While high, bit 7 of `SPRITES_EN` is forced low so the loader stalls.
- `REQ` input 7: request pulses, one bit per overlay.
  - Bit map: [6] blue, [5] green, [4] red, [3] yellow, [2] lose, [1] win, [0] pwr.
  - Any bit high for one or more cycles queues that sprite.
- `FRAME_DONE` input 1: one-cycle pulse at the end of each loaded frame.
- `SPRITES_EN` output 8: registered.
  - [7] is the background/run flag.
  - [6:0] use the same bit map as `REQ`.
- `ACK` output 7: one-cycle pulse on the bit of the sprite whose hold period just finished.
- `BUSY` output 1: high whenever any request is pending or an overlay is shown.

## Operation
- **Pending register `PEND[6:0]`.**
  - Each cycle: `PEND <= (PEND & ~clr) | REQ`.
  - `clr` is the one-hot bit taken into SHOW.
  - A REQ on the same bit in the same cycle as its clear wins: the request is re-queued.
- **Priority** (highest first): lose, win, pwr, blue, green, red, yellow.
- **States:**
  - IDLE:
    - `SPRITES_EN = 0`.
    - Goes to BG when `ENABLE` is high (no frame boundary needed, since the loader is idle).
  - BG:
    - `SPRITES_EN = 8'h80`.
    - On `FRAME_DONE`:
      - if `ENABLE` is low, go to IDLE;
      - else if `PEND != 0`, load `CUR` with the highest-priority pending bit, clear it, load the frame counter with `HOLD_FRAMES-1`, and go to SHOW;
      - else stay in BG.
  - SHOW:
    - `SPRITES_EN = {1'b1, CUR}`.
    - On `FRAME_DONE`:
      - if `ENABLE` is low, go to IDLE, with no ACK and `CUR` cleared;
      - else if the lose bit is pending and `CUR` is not lose, preempt: pulse `ACK` for the old `CUR`, switch to lose, and reload the counter;
      - else if the counter is 0, pulse `ACK` for `CUR`, then go to SHOW with the next pending sprite if any (same rules as BG), else to BG;
      - else decrement the counter.
- **PAUSE** is an overlay on the state, not a separate state. It forces output bit 7 to 0 but does not stop the FSM or the counter. FRAME_DONE pulses are not expected while paused, and any that arrive are still honoured.
- **Frame counter:** 8 bits, unsigned, never wraps. A decrement happens only when the counter is nonzero.
- **BUSY** = `(PEND != 0) | (state == SHOW)`.

## Timing
- **Reset values:**
  - `SPRITES_EN = 0`, `ACK = 0`, `BUSY = 0`.
  - State is IDLE; `PEND`, `CUR` and the counter are 0.
- **REQ capture:** a REQ bit sampled at edge n appears in `PEND` and `BUSY` at n+1.
- **Frame-boundary transitions:** with `FRAME_DONE` high at edge n, the new `SPRITES_EN` and any `ACK` pulse are visible after edge n. `ACK` lasts exactly one cycle.
- **IDLE to BG:** `SPRITES_EN` goes to `8'h80` one cycle after `ENABLE` is sampled high.
- **PAUSE:** combinational mask on the registered bit 7. Latency 0 cycles.
- **Hold length:** an overlay is shown for exactly `HOLD_FRAMES` `FRAME_DONE` pulses, counting from the pulse after it was selected.
- **Mid-operation RESET:** outputs go to their reset values immediately (asynchronously) and pending requests are discarded.
- **REQ while in SHOW:** the request is queued only and never changes the current frame, except lose, which preempts at the next boundary.

## Test plan
- **Basic overlay cycle.** Set `HOLD_FRAMES`=2, `ENABLE`=1, pulse `REQ`=7'h40, then send 3 `FRAME_DONE` pulses. Expect:
  - `SPRITES_EN` = 80, then C0 after the first pulse;
  - C0 held until the third pulse;
  - then `ACK`=40 for one cycle and `SPRITES_EN` back to 80.
- **Priority and queueing.** Pulse `REQ`=7'h49 in BG, then send a frame boundary. Expect:
  - pwr shown first (`SPRITES_EN`=81);
  - then blue (C0);
  - then yellow (88);
  - 3 ACKs in that order and `BUSY`=0 at the end.
- **Lose preemption.** While green (A0) is shown, pulse `REQ`=7'h04. Expect:
  - at the next `FRAME_DONE`, `ACK`=20 and `SPRITES_EN`=84;
  - lose held for `HOLD_FRAMES` frames.
- **Set-over-clear.** Assert `REQ`=7'h10 in the same cycle that red is selected from `PEND`. Expect `PEND` bit 4 still set and red shown twice back to back.
- **PAUSE and ENABLE.** Hold `PAUSE` high in SHOW with `SPRITES_EN`=90 and expect 10; release and expect 90. Drop `ENABLE` and send `FRAME_DONE`; expect 00, no `ACK`, state IDLE.
- **Async reset mid-SHOW.** Assert `RESET` between clock edges. Expect all outputs 0 immediately and no `ACK` after reset is released.
